// File: rtl/mic_sequencer.sv
// Mic-1 microprogram sequencer: writable 512x36 control store, MPC/MIR, branch logic,
// memory-ready stall, halt address and a saturating microcycle counter.
module mic_sequencer #(
  parameter logic [8:0] START_ADDR = 9'h000,
  parameter logic [8:0] HALT_ADDR  = 9'h1FF,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             N,
  input  logic             Z,
  input  logic [7:0]       MBR,
  input  logic             mem_ready,
  input  logic             cs_we,
  input  logic [8:0]       cs_waddr,
  input  logic [35:0]      cs_wdata,
  output logic [8:0]       Addr,
  output logic [2:0]       J,
  output logic [7:0]       ULA_ctrl,
  output logic [8:0]       C,
  output logic [2:0]       Mem,
  output logic [3:0]       B,
  output logic [8:0]       mpc,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] ucycles
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_t;

  state_t      state;
  logic [35:0] cs [0:511];
  logic [35:0] mir;
  logic [8:0]  mpc_next;
  logic        active;
  logic        fire;
  logic        cs_wr_ok;

  assign active   = (state == RUN) || (state == WAIT);
  // A memory-issuing instruction only executes in a cycle where memory accepts it.
  assign fire     = active && ((mir[6:4] == 3'b000) || mem_ready);
  assign cs_wr_ok = cs_we && !start && !rst && ((state == IDLE) || (state == HALT));

  always_comb begin
    mpc_next[8]   = mir[35] | (mir[25] & N) | (mir[24] & Z);
    mpc_next[7:0] = mir[26] ? (mir[34:27] | MBR) : mir[34:27];
  end

  always_ff @(posedge clk) begin
    if (cs_wr_ok) begin
      cs[cs_waddr] <= cs_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mpc     <= 9'h000;
      mir     <= 36'h0;
      ucycles <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            mpc   <= START_ADDR;
            mir   <= cs[START_ADDR];
            state <= RUN;
          end
        end
        RUN, WAIT: begin
          if (fire) begin
            ucycles <= (&ucycles) ? ucycles : ucycles + 1'b1;
            // The halt instruction still executes, but MPC/MIR stay parked on it.
            if (mpc == HALT_ADDR) begin
              state <= HALT;
            end else begin
              mpc   <= mpc_next;
              mir   <= cs[mpc_next];
              state <= RUN;
            end
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Addr     = fire ? mir[35:27] : 9'h000;
  assign J        = fire ? mir[26:24] : 3'b000;
  assign ULA_ctrl = fire ? mir[23:16] : 8'h00;
  assign C        = fire ? mir[15:7]  : 9'h000;
  assign Mem      = fire ? mir[6:4]   : 3'b000;
  assign B        = fire ? mir[3:0]   : 4'h0;
  assign busy     = active;
  assign halted   = (state == HALT);

endmodule

// File: tb/tb_mic_sequencer.sv
// Testbench for mic_sequencer: directed Mic-1 microprogram scenarios followed by random
// traffic, all compared against a behavioural program-counter model of the sequencer.
module tb_mic_sequencer;

  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, N, Z, mem_ready, cs_we;
  logic [7:0]    MBR;
  logic [8:0]    cs_waddr;
  logic [35:0]   cs_wdata;
  logic [8:0]    Addr, C, mpc;
  logic [2:0]    J, Mem;
  logic [7:0]    ULA_ctrl;
  logic [3:0]    B;
  logic          busy, halted;
  logic [CW-1:0] ucycles;

  mic_sequencer #(.START_ADDR(9'h000), .HALT_ADDR(9'h1FF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .N(N), .Z(Z), .MBR(MBR),
    .mem_ready(mem_ready), .cs_we(cs_we), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata),
    .Addr(Addr), .J(J), .ULA_ctrl(ULA_ctrl), .C(C), .Mem(Mem), .B(B),
    .mpc(mpc), .busy(busy), .halted(halted), .ucycles(ucycles)
  );

  int checks = 0;
  int errors = 0;

  // Model: the instruction being executed is simply the stored word at the model PC,
  // since the store cannot change while a program is running.
  logic [35:0] m_cs [512];
  bit          m_active, m_halted;
  logic [8:0]  m_pc;
  int          m_cnt;

  function automatic logic [35:0] mk(int nxt, int jam, int ula, int c, int mem, int b);
    return {9'(nxt), 3'(jam), 8'(ula), 9'(c), 3'(mem), 4'(b)};
  endfunction

  function automatic logic [8:0] target(logic [35:0] ir, logic n, logic z, logic [7:0] mbr);
    int hi, lo;
    hi = (ir[35] || (ir[25] && n) || (ir[24] && z)) ? 256 : 0;
    lo = ir[26] ? int'(ir[34:27] | mbr) : int'(ir[34:27]);
    return 9'(hi + lo);
  endfunction

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs driven; checks outputs, then advances one edge.
  task automatic cycle();
    logic [35:0] ir;
    bit          fire;
    #1;
    ir   = m_cs[m_pc];
    fire = m_active && ((ir[6:4] == 3'b000) || mem_ready);
    check("ctrl", {Addr, J, ULA_ctrl, C, Mem, B}, fire ? ir : 36'h0);
    check("mpc", 36'(mpc), 36'(m_pc));
    check("busy", 36'(busy), 36'(m_active));
    check("halted", 36'(halted), 36'(m_halted));
    check("ucycles", 36'(ucycles), 36'(m_cnt));
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_halted = 0; m_pc = 9'h000; m_cnt = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_halted = 0; m_pc = 9'h000;
      end else if (cs_we) begin
        m_cs[cs_waddr] = cs_wdata;
      end
    end else if (fire) begin
      if (m_cnt < (2 ** CW) - 1) m_cnt++;
      if (m_pc == 9'h1FF) begin
        m_active = 0; m_halted = 1;
      end else begin
        m_pc = target(ir, N, Z, MBR);
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input int addr, input logic [35:0] data);
    cs_we = 1'b1; cs_waddr = 9'(addr); cs_wdata = data;
    cycle();
    cs_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic finish_run();
    for (int i = 0; i < 20 && !m_halted; i++) cycle();
    #1 check("run_halted", 36'(halted), 36'(1));
  endtask

  initial begin
    logic [63:0] r;
    logic [8:0]  seq [4];
    seq = '{9'h000, 9'h001, 9'h002, 9'h1FF};
    rst = 1'b1; start = 0; N = 0; Z = 0; MBR = 8'h00; mem_ready = 1'b1;
    cs_we = 0; cs_waddr = 9'h000; cs_wdata = 36'h0;
    @(negedge clk);
    m_active = 0; m_halted = 0; m_pc = 9'h000; m_cnt = 0;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    #1 check("idle_ctrl", {Addr, J, ULA_ctrl, C, Mem, B}, 36'h0);

    for (int i = 0; i < 512; i++) begin
      r = {$urandom(), $urandom()};
      wr(i, r[35:0]);
    end

    // Linear program 0 -> 1 -> 2 -> halt.
    wr(9'h000, mk(1, 0, 0, 0, 0, 0));
    wr(9'h001, mk(2, 0, 0, 0, 0, 0));
    wr(9'h002, mk(9'h1FF, 0, 0, 0, 0, 0));
    wr(9'h1FF, mk(0, 0, 0, 9'h010, 0, 0));
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      #1 check("lin_mpc", 36'(mpc), 36'(seq[k]));
      if (k == 3) check("lin_C", 36'(C), 36'h010);
      cycle();
    end
    #1 check("lin_halted", 36'(halted), 36'(1));
    check("lin_C_after", 36'(C), 36'h0);
    check("lin_ucycles", 36'(ucycles), 36'(4));

    // Write to 0x005 and observe it executing.
    wr(9'h000, mk(5, 0, 0, 0, 0, 0));
    wr(9'h005, mk(9'h1FF, 0, 8'h3C, 0, 0, 4'hA));
    pulse_start();
    cycle();
    #1 check("rd5_mpc", 36'(mpc), 36'h005);
    check("rd5_ula", 36'(ULA_ctrl), 36'h3C);
    check("rd5_b", 36'(B), 36'hA);
    finish_run();

    // JAMZ / JAMN branches.
    wr(9'h000, mk(9'h010, 0, 0, 0, 0, 0));
    wr(9'h010, mk(9'h020, 1, 0, 0, 0, 0));
    wr(9'h020, mk(9'h1FF, 0, 0, 0, 0, 0));
    wr(9'h120, mk(9'h1FF, 0, 0, 0, 0, 0));
    Z = 1'b1;
    pulse_start(); cycle(); cycle();
    #1 check("jamz_taken", 36'(mpc), 36'h120);
    finish_run();
    Z = 1'b0;
    pulse_start(); cycle(); cycle();
    #1 check("jamz_not", 36'(mpc), 36'h020);
    finish_run();
    wr(9'h010, mk(9'h020, 2, 0, 0, 0, 0));
    N = 1'b1; Z = 1'b1;
    pulse_start(); cycle(); cycle();
    #1 check("jamn_taken", 36'(mpc), 36'h120);
    finish_run();
    N = 1'b0; Z = 1'b0;

    // JMPC dispatch.
    wr(9'h000, mk(9'h000, 4, 0, 0, 0, 0));
    wr(9'h060, mk(9'h1FF, 0, 0, 0, 0, 0));
    MBR = 8'h60;
    pulse_start(); cycle();
    #1 check("jmpc_60", 36'(mpc), 36'h060);
    finish_run();
    wr(9'h000, mk(9'h100, 4, 0, 0, 0, 0));
    wr(9'h1A7, mk(9'h1FF, 0, 0, 0, 0, 0));
    MBR = 8'hA7;
    pulse_start(); cycle();
    #1 check("jmpc_1a7", 36'(mpc), 36'h1A7);
    finish_run();
    MBR = 8'h00;

    // Memory stall: three cycles not ready, then one accepted request.
    wr(9'h000, mk(1, 0, 0, 9'h001, 2, 0));
    wr(9'h001, mk(9'h1FF, 0, 0, 0, 0, 0));
    mem_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_mem", 36'(Mem), 36'h0);
      check("stall_c", 36'(C), 36'h0);
      check("stall_mpc", 36'(mpc), 36'h000);
      cycle();
    end
    mem_ready = 1'b1;
    #1 check("go_mem", 36'(Mem), 36'h2);
    check("go_c", 36'(C), 36'h001);
    cycle();
    #1 check("go_mpc", 36'(mpc), 36'h001);
    check("go_mem_once", 36'(Mem), 36'h0);
    finish_run();

    // Write lockout while running, then reset out of WAIT.
    wr(9'h000, mk(1, 0, 0, 0, 1, 0));
    wr(9'h001, mk(9'h1FF, 0, 8'h55, 0, 0, 0));
    pulse_start();
    cs_we = 1'b1; cs_waddr = 9'h001; cs_wdata = mk(9'h1FF, 0, 8'hAA, 0, 0, 0);
    cycle();
    cs_we = 1'b0;
    #1 check("lock_ula", 36'(ULA_ctrl), 36'h55);
    finish_run();
    mem_ready = 1'b0;
    pulse_start(); cycle();
    #1 check("wait_busy", 36'(busy), 36'(1));
    rst = 1'b1; cycle(); rst = 1'b0;
    #1 check("rst_busy", 36'(busy), 36'(0));
    check("rst_mem", 36'(Mem), 36'h0);
    mem_ready = 1'b1;
    pulse_start();
    #1 check("restart_mpc", 36'(mpc), 36'h000);
    check("restart_mem", 36'(Mem), 36'h1);
    finish_run();

    // Random traffic, including restarts, writes, rare resets and counter saturation.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(7) == 0);
      N         = 1'($urandom());
      Z         = 1'($urandom());
      MBR       = 8'($urandom());
      mem_ready = ($urandom_range(2) != 0);
      cs_we     = ($urandom_range(3) == 0);
      cs_waddr  = 9'($urandom());
      r         = {$urandom(), $urandom()};
      cs_wdata  = r[35:0];
      rst       = ($urandom_range(299) == 0);
      cycle();
    end
    rst = 1'b0; start = 1'b0; cs_we = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
